// File: rtl/cla_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined radix-4 carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_RADIX = 4;

    // Depth of the radix-4 lookahead tree, i.e. log4(width).
    function automatic int unsigned cla_levels(input int unsigned width);
        int unsigned lvl;
        int unsigned w;
        lvl = 0;
        w   = width;
        while (w > 1) begin
            w   = w / CLA_RADIX;
            lvl = lvl + 1;
        end
        return lvl;
    endfunction

    function automatic bit cla_width_ok(input int unsigned width);
        return (width == 4) || (width == 16) || (width == 64);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Radix-4 carry generator: group G/P plus the three internal carries from a group carry-in.
module cla_group4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       cin_i,
    output logic [3:1] carry_o,
    output logic       g_o,
    output logic       p_o
);

    // Separate assigns keep G/P independent of cin_i so the up/down tree stays acyclic.
    assign carry_o[1] = g_i[0] | (p_i[0] & cin_i);
    assign carry_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    assign carry_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                      | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    assign g_o        = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                      | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign p_o        = &p_i;

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined hierarchical carry-lookahead adder with valid/ready on both sides.
// Optional Z/N/V flag outputs are built when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             blk_g,
    output logic             blk_p
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
`endif
);

    localparam int unsigned LEVELS = cla_levels(WIDTH);

    if (!cla_width_ok(WIDTH)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be 4, 16 or 64");
    end

    logic             s1_valid_q, s1_valid_d, s1_cin_q, s1_cin_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d;
    logic             s2_valid_q, s2_valid_d, s2_cout_q, s2_cout_d;
    logic             s2_bg_q, s2_bg_d, s2_bp_q, s2_bp_d;
    logic [WIDTH-1:0] s2_c_q, s2_c_d, s2_p_q, s2_p_d;
    logic             s3_valid_q, s3_valid_d, cout_q, cout_d;
    logic             blk_g_q, blk_g_d, blk_p_q, blk_p_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             adv1, adv2, adv3, accept;
    logic             top_g, top_p;
    logic [WIDTH-1:0] bit_c;

    // Level l has WIDTH/4^l nodes; G/P flow up from S1, carries flow back down to the bits.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NL = WIDTH >> (2 * l);
        logic [4*NL-1:0] child_g, child_p, cdn;
        logic [NL-1:0]   gg, pp, cv;

        if (l == 1) begin : g_leaf
            assign child_g = s1_g_q;
            assign child_p = s1_p_q;
        end else begin : g_inner
            assign child_g = g_lvl[l-1].gg;
            assign child_p = g_lvl[l-1].pp;
        end

        if (l == LEVELS) begin : g_root
            assign cv = s1_cin_q;
        end else begin : g_mid
            assign cv = g_lvl[l+1].cdn;
        end

        for (genvar j = 0; j < NL; j++) begin : g_grp
            cla_group4 u_grp (
                .g_i    (child_g[4*j +: 4]),
                .p_i    (child_p[4*j +: 4]),
                .cin_i  (cv[j]),
                .carry_o(cdn[4*j+1 +: 3]),
                .g_o    (gg[j]),
                .p_o    (pp[j])
            );
            assign cdn[4*j] = cv[j];
        end
    end

    assign bit_c = g_lvl[1].cdn;
    assign top_g = g_lvl[LEVELS].gg[0];
    assign top_p = g_lvl[LEVELS].pp[0];

    always_comb begin
        adv3     = out_ready;
        adv2     = s2_valid_q & (~s3_valid_q | adv3);
        adv1     = s1_valid_q & (~s2_valid_q | adv2);
        in_ready = ~s1_valid_q | adv1;
        accept   = in_valid & in_ready;

        s1_valid_d = accept | (s1_valid_q & ~adv1);
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_cin_d   = s1_cin_q;
        if (accept) begin
            s1_g_d   = a & b;
            s1_p_d   = a ^ b;
            s1_cin_d = cin;
        end

        s2_valid_d = adv1 | (s2_valid_q & ~adv2);
        s2_c_d     = s2_c_q;
        s2_p_d     = s2_p_q;
        s2_cout_d  = s2_cout_q;
        s2_bg_d    = s2_bg_q;
        s2_bp_d    = s2_bp_q;
        if (adv1) begin
            s2_c_d    = bit_c;
            s2_p_d    = s1_p_q;
            s2_cout_d = top_g | (top_p & s1_cin_q);
            s2_bg_d   = top_g;
            s2_bp_d   = top_p;
        end

        s3_valid_d = adv2 | (s3_valid_q & ~adv3);
        sum_d      = sum_q;
        cout_d     = cout_q;
        blk_g_d    = blk_g_q;
        blk_p_d    = blk_p_q;
        if (adv2) begin
            sum_d   = s2_p_q ^ s2_c_q;
            cout_d  = s2_cout_q;
            blk_g_d = s2_bg_q;
            blk_p_d = s2_bp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_c_q     <= '0;
            s2_p_q     <= '0;
            s2_cout_q  <= 1'b0;
            s2_bg_q    <= 1'b0;
            s2_bp_q    <= 1'b0;
            s3_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            blk_g_q    <= 1'b0;
            blk_p_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_c_q     <= s2_c_d;
            s2_p_q     <= s2_p_d;
            s2_cout_q  <= s2_cout_d;
            s2_bg_q    <= s2_bg_d;
            s2_bp_q    <= s2_bp_d;
            s3_valid_q <= s3_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            blk_g_q    <= blk_g_d;
            blk_p_q    <= blk_p_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign blk_g     = blk_g_q;
    assign blk_p     = blk_p_q;

`ifdef CLA_PIPE_FLAGS_EN
    logic flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_v_q, flag_v_d;

    // Overflow is carry into the MSB versus carry out of it.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        if (adv2) begin
            flag_z_d = ~|(s2_p_q ^ s2_c_q);
            flag_n_d = s2_p_q[WIDTH-1] ^ s2_c_q[WIDTH-1];
            flag_v_d = s2_c_q[WIDTH-1] ^ s2_cout_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: scoreboarded WIDTH=16 and WIDTH=64 instances,
// plus a WIDTH=4 flag instance when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        g;
        logic        p;
    } exp16_t;

    exp16_t      q16[$];
    logic [64:0] q64[$];

    logic        iv16 = 0, or16 = 0, cin16 = 0, ir16, ov16, cout16, bg16, bp16;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic        iv64 = 0, or64 = 0, cin64 = 0, ir64, ov64, cout64, bg64, bp64;
    logic [63:0] a64 = 0, b64 = 0, sum64;

`ifdef CLA_PIPE_FLAGS_EN
    logic        fz16, fn16, fv16, fz64, fn64, fv64;
    logic        iv4 = 0, or4 = 0, cin4 = 0, ir4, ov4, cout4, bg4, bp4, fz4, fn4, fv4;
    logic [3:0]  a4 = 0, b4 = 0, sum4;
    logic [7:0]  q4[$];
`endif

    cla_pipe_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16),
        .blk_g(bg16), .blk_p(bp16)
`ifdef CLA_PIPE_FLAGS_EN
        , .flag_z(fz16), .flag_n(fn16), .flag_v(fv16)
`endif
    );

    cla_pipe_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .cin(cin64), .out_valid(ov64), .out_ready(or64), .sum(sum64), .cout(cout64),
        .blk_g(bg64), .blk_p(bp64)
`ifdef CLA_PIPE_FLAGS_EN
        , .flag_z(fz64), .flag_n(fn64), .flag_v(fv64)
`endif
    );

`ifdef CLA_PIPE_FLAGS_EN
    cla_pipe_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4),
        .blk_g(bg4), .blk_p(bp4), .flag_z(fz4), .flag_n(fn4), .flag_v(fv4)
    );
`endif

    function automatic exp16_t model16(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin);
        logic [16:0] full;
        logic [16:0] gen;
        exp16_t e;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        gen    = {1'b0, a} + {1'b0, b};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.g    = gen[16];
        e.p    = &(a ^ b);
        return e;
    endfunction

    // Called just after a falling edge: applies inputs and records the op if it will transfer.
    task automatic drive16(input logic iv, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic ordy);
        iv16 = iv; a16 = a; b16 = b; cin16 = cin; or16 = ordy;
        #1;
        if (iv && ir16) q16.push_back(model16(a, b, cin));
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ov16, sum16, cout16, bg16, bp16} !== 20'd0)
            $display("FAIL reset16: got v=%b sum=%h c=%b g=%b p=%b want all 0",
                     ov16, sum16, cout16, bg16, bp16);
        else passed++;
        checks++;
        if ({ov64, sum64, cout64, bg64, bp64} !== 68'd0)
            $display("FAIL reset64: got v=%b sum=%h want all 0", ov64, sum64);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({ir16, ir64} !== 2'b11) $display("FAIL reset_ready: got %b%b want 11", ir16, ir64);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] va[7] = '{16'hFFFF, 16'hAAAA, 16'h0000, 16'h1234, 16'h8000, 16'hFFFF, 16'h0F0F};
        logic [15:0] vb[7] = '{16'h0001, 16'h5555, 16'h0000, 16'h4321, 16'h8000, 16'hFFFF, 16'hF0F0};
        logic        vc[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp16_t e;
        for (int i = 0; i < 7 + 4; i++) begin
            @(negedge clk);
            if (i < 7) drive16(1'b1, va[i], vb[i], vc[i], 1'b1);
            else drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            checks++;
            if (ov16 !== (i >= 3 && i < 10))
                $display("FAIL b2b_valid cycle %0d: got %b want %b", i, ov16, (i >= 3 && i < 10));
            else passed++;
            if (ov16 && or16) begin
                checks++;
                if (q16.size() == 0) $display("FAIL b2b: unexpected result sum=%h", sum16);
                else begin
                    e = q16.pop_front();
                    if ({sum16, cout16, bg16, bp16} !== e)
                        $display("FAIL b2b: got sum=%h c=%b g=%b p=%b want sum=%h c=%b g=%b p=%b",
                                 sum16, cout16, bg16, bp16, e.sum, e.cout, e.g, e.p);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        exp16_t e;
        int acc;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive16(1'b1, 16'h1111 * 16'(acc + 1), 16'h0F00, 1'b1, 1'b0);
            checks++;
            if (ir16 !== (i < 3)) $display("FAIL bp_ready cycle %0d: got %b want %b", i, ir16, (i < 3));
            else passed++;
            if (ir16) acc++;
            if (i >= 3) begin
                checks++;
                if (!ov16 || {sum16, cout16, bg16, bp16} !== q16[0])
                    $display("FAIL bp_hold cycle %0d: got v=%b sum=%h want v=1 sum=%h",
                             i, ov16, sum16, q16[0].sum);
                else passed++;
            end
        end
        checks++;
        if (q16.size() != 3) $display("FAIL bp_accepted: got %0d want 3", q16.size());
        else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (ov16 && or16) begin
                checks++;
                if (q16.size() == 0) $display("FAIL bp_drain: unexpected result sum=%h", sum16);
                else begin
                    e = q16.pop_front();
                    if ({sum16, cout16, bg16, bp16} !== e)
                        $display("FAIL bp_drain: got sum=%h c=%b want sum=%h c=%b",
                                 sum16, cout16, e.sum, e.cout);
                    else passed++;
                end
            end
        end
        checks++;
        if (q16.size() != 0) $display("FAIL bp_drained: got %0d left want 0", q16.size());
        else passed++;
    endtask

    task automatic test_random_stall();
        exp16_t e;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk);
            drive16(i < 300 && $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom), i >= 300 || $urandom_range(0, 9) < 7);
            if (ov16 && or16) begin
                checks++;
                if (q16.size() == 0) $display("FAIL rnd16: unexpected result sum=%h", sum16);
                else begin
                    e = q16.pop_front();
                    if ({sum16, cout16, bg16, bp16} !== e)
                        $display("FAIL rnd16: got sum=%h c=%b g=%b p=%b want sum=%h c=%b g=%b p=%b",
                                 sum16, cout16, bg16, bp16, e.sum, e.cout, e.g, e.p);
                    else passed++;
                end
            end
        end
        checks++;
        if (q16.size() != 0) $display("FAIL rnd16_drained: got %0d left want 0", q16.size());
        else passed++;
    endtask

    task automatic test_reset_midstream();
        exp16_t e;
        int first;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive16(1'b1, 16'h7000 + 16'(i), 16'h0123, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov16 !== 1'b0 || sum16 !== 16'h0)
            $display("FAIL midreset: got v=%b sum=%h want v=0 sum=0000", ov16, sum16);
        else passed++;
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive16(1'b1, 16'h3C3C, 16'h4141, 1'b1, 1'b1);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (ov16) begin
                if (first < 0) first = k;
                checks++;
                if (q16.size() == 0) $display("FAIL midreset_stale: unexpected sum=%h", sum16);
                else begin
                    e = q16.pop_front();
                    if ({sum16, cout16, bg16, bp16} !== e)
                        $display("FAIL midreset_op: got sum=%h want sum=%h", sum16, e.sum);
                    else passed++;
                end
            end
        end
        checks++;
        if (first != 3) $display("FAIL midreset_latency: got %0d want 3", first);
        else passed++;
    endtask

    task automatic test_random64();
        logic [63:0] ra, rb;
        logic        rc;
        logic [64:0] e;
        int          acc, res;
        acc = 0;
        res = 0;
        for (int i = 0; i < 1003; i++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            iv64 = (i < 1000); a64 = ra; b64 = rb; cin64 = rc; or64 = 1'b1;
            #1;
            if (iv64 && ir64) begin
                q64.push_back({1'b0, ra} + {1'b0, rb} + {64'd0, rc});
                acc++;
            end
            if (ov64 && or64) begin
                res++;
                checks++;
                if (q64.size() == 0) $display("FAIL rnd64: unexpected result sum=%h", sum64);
                else begin
                    e = q64.pop_front();
                    if ({cout64, sum64} !== e)
                        $display("FAIL rnd64: got c=%b sum=%h want c=%b sum=%h",
                                 cout64, sum64, e[64], e[63:0]);
                    else passed++;
                end
            end
        end
        iv64 = 1'b0;
        checks++;
        if (acc != 1000 || res != 1000)
            $display("FAIL rnd64_throughput: got acc=%0d res=%0d want 1000/1000", acc, res);
        else passed++;
    endtask

`ifdef CLA_PIPE_FLAGS_EN
    task automatic test_flags();
        logic [3:0] va[4] = '{4'h7, 4'h8, 4'h3, 4'hF};
        logic [3:0] vb[4] = '{4'h1, 4'h8, 4'h2, 4'h1};
        logic       vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [4:0] full;
        logic [7:0] e;
        for (int i = 0; i < 4 + 5; i++) begin
            @(negedge clk);
            iv4 = (i < 4); or4 = 1'b1;
            if (i < 4) begin a4 = va[i]; b4 = vb[i]; cin4 = vc[i]; end
            #1;
            if (iv4 && ir4) begin
                full = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
                // {sum, cout, z, n, v}
                q4.push_back({full[3:0], full[4], full[3:0] == 4'd0, full[3],
                              (a4[3] == b4[3]) && (full[3] != a4[3])});
            end
            if (ov4 && or4) begin
                checks++;
                if (q4.size() == 0) $display("FAIL flags: unexpected result sum=%h", sum4);
                else begin
                    e = q4.pop_front();
                    if ({sum4, cout4, fz4, fn4, fv4} !== e)
                        $display("FAIL flags: got sum=%h c=%b z=%b n=%b v=%b want %b",
                                 sum4, cout4, fz4, fn4, fv4, e);
                    else passed++;
                end
            end
        end
        iv4 = 1'b0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_midstream();
        test_random64();
`ifdef CLA_PIPE_FLAGS_EN
        test_flags();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
